// File: rtl/konami_addr_decoder.sv
// konami_addr_decoder: priority base/mask chip-select decoder with per-region wait states and a bank register.
// Optional watchdog built when KONAMI_DECODE_WATCHDOG_EN is defined.
module konami_addr_decoder #(
  parameter int ADDR_W = 16,
  parameter int NREG = 6,
  parameter logic [NREG*ADDR_W-1:0] BASE = '0,
  parameter logic [NREG*ADDR_W-1:0] MASK = '0,
  parameter logic [NREG*4-1:0] WS = '0,
  parameter int BANK_REG = 0,
  parameter int BANK_W = 5,
  parameter int WD_REG = 1,
  parameter int WD_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_vma,
  input  logic              cpu_rw,
  input  logic [7:0]        cpu_dout,
  output logic [NREG-1:0]   cs_n,
  output logic              cpu_wait_n,
  output logic [BANK_W-1:0] bank,
  output logic              wd_rst_n
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [NREG-1:0] sel_n;
  logic [3:0] sel_ws;
  logic unused_dout;
  assign unused_dout = ^cpu_dout;
  // walk from the highest index down so the lowest matching region is the last one written
  always_comb begin
    sel_n = '1;
    sel_ws = '0;
    for (int i = NREG - 1; i >= 0; i--)
      if ((cpu_addr & MASK[i*ADDR_W +: ADDR_W]) == (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W])) begin
        sel_n = ~(NREG'(1) << i);
        sel_ws = WS[i*4 +: 4];
      end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      cs_n <= '1;
      cpu_wait_n <= 1'b1;
      bank <= '0;
    end else
      case (state)
        IDLE:
          if (cpu_vma) begin
            cs_n <= sel_n;
            if (!cpu_rw && !sel_n[BANK_REG]) bank <= cpu_dout[BANK_W-1:0];
            if (sel_ws != 4'd0) begin
              cnt <= sel_ws;
              cpu_wait_n <= 1'b0;
              state <= WAIT;
            end else
              state <= HOLD;
          end
        WAIT:
          if (!cpu_vma) begin
            cs_n <= '1;
            cpu_wait_n <= 1'b1;
            cnt <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              cpu_wait_n <= 1'b1;
              state <= HOLD;
            end
          end
        default:
          if (!cpu_vma) begin
            cs_n <= '1;
            state <= IDLE;
          end
      endcase
`ifdef KONAMI_DECODE_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_TIMEOUT + 1) > 16 ? $clog2(WD_TIMEOUT + 1) : 16;
  logic [WD_W-1:0] wd_cnt;
  logic [4:0] wd_pulse;
  logic kick;
  assign kick = state == IDLE && cpu_vma && !cpu_rw && !sel_n[WD_REG];
  // a running pulse always completes its 16 cycles; kicks only clear the counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wd_cnt <= '0;
      wd_pulse <= '0;
      wd_rst_n <= 1'b1;
    end else if (wd_pulse != 5'd0) begin
      wd_pulse <= wd_pulse - 5'd1;
      wd_rst_n <= wd_pulse == 5'd1;
      wd_cnt <= (kick || wd_pulse == 5'd1) ? '0 : wd_cnt;
    end else if (kick)
      wd_cnt <= '0;
    else if (wd_cnt == WD_W'(WD_TIMEOUT - 1)) begin
      wd_cnt <= wd_cnt + 1'b1;
      wd_pulse <= 5'd16;
      wd_rst_n <= 1'b0;
    end else
      wd_cnt <= wd_cnt + 1'b1;
`else
  logic unused_wd;
  assign unused_wd = ^{WD_REG, WD_TIMEOUT};
  assign wd_rst_n = 1'b1;
`endif
endmodule

// File: tb/tb_konami_addr_decoder.sv
// tb_konami_addr_decoder: randomized scoreboard bench; a 3-region and a 4-region decoder share one CPU bus.
module tb_konami_addr_decoder;
  logic clk = 1'b0;
  logic reset_n, vma, rw;
  logic [15:0] addr;
  logic [7:0] dout;
  logic [2:0] cs3_n;
  logic [3:0] cs4_n;
  logic wait3_n, wait4_n, wd3_n, wd4_n;
  logic [4:0] bank3, bank4;
  int checks = 0, errors = 0, wd_lows = 0;
  logic [4:0] mbank = '0;
  logic [15:0] base3[3] = '{16'h0000, 16'h5F80, 16'h4000};
  logic [15:0] mask3[3] = '{16'hE000, 16'hFFF0, 16'hC000};
  int ws3[3] = '{0, 0, 2};
  logic [15:0] base4[4] = '{16'h8000, 16'hC000, 16'h0000, 16'h0000};
  logic [15:0] mask4[4] = '{16'hC000, 16'hC000, 16'hE000, 16'hFF00};
  typedef struct { logic [2:0] cs3; logic w3; logic [4:0] bank; logic [3:0] cs4; } exp_t;
  exp_t q[$];

  konami_addr_decoder #(.ADDR_W(16), .NREG(3), .BASE({16'h4000, 16'h5F80, 16'h0000}),
    .MASK({16'hC000, 16'hFFF0, 16'hE000}), .WS({4'd2, 4'd0, 4'd0}), .BANK_REG(1), .BANK_W(5),
    .WD_REG(0), .WD_TIMEOUT(100)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(addr), .cpu_vma(vma), .cpu_rw(rw), .cpu_dout(dout),
    .cs_n(cs3_n), .cpu_wait_n(wait3_n), .bank(bank3), .wd_rst_n(wd3_n));

  konami_addr_decoder #(.ADDR_W(16), .NREG(4), .BASE({16'h0000, 16'h0000, 16'hC000, 16'h8000}),
    .MASK({16'hFF00, 16'hE000, 16'hC000, 16'hC000}), .WS('0), .BANK_REG(1), .BANK_W(5),
    .WD_REG(0), .WD_TIMEOUT(100)) dut4 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(addr), .cpu_vma(vma), .cpu_rw(rw), .cpu_dout(dout),
    .cs_n(cs4_n), .cpu_wait_n(wait4_n), .bank(bank4), .wd_rst_n(wd4_n));

  always #5 clk = ~clk;

  always @(negedge clk) if (!wd3_n) wd_lows++;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int win3(input logic [15:0] a);
    for (int i = 0; i < 3; i++) if ((a & mask3[i]) == (base3[i] & mask3[i])) return i;
    return -1;
  endfunction

  function automatic int win4(input logic [15:0] a);
    for (int i = 0; i < 4; i++) if ((a & mask4[i]) == (base4[i] & mask4[i])) return i;
    return -1;
  endfunction

  // one access: vma high for len sampled edges, then low for gap edges; addr moves to a2 after the first edge
  task automatic access(input logic [15:0] a, input logic wr, input logic [7:0] d, input int len, input int gap, input logic [15:0] a2);
    int i3 = win3(a);
    int i4 = win4(a);
    int ws = i3 < 0 ? 0 : ws3[i3];
    addr = a; rw = !wr; dout = d; vma = 1'b1;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk);
      if (k == 1 && wr && i3 == 1) mbank = d[4:0];
      q.push_back('{cs3: i3 < 0 ? 3'b111 : ~(3'b001 << i3), w3: !(i3 >= 0 && k <= ws), bank: mbank,
                    cs4: i4 < 0 ? 4'b1111 : ~(4'b0001 << i4)});
      #1 addr = a2;
    end
    vma = 1'b0;
    for (int k = 0; k < gap; k++) begin
      @(posedge clk);
      q.push_back('{cs3: 3'b111, w3: 1'b1, bank: mbank, cs4: 4'b1111});
      #1 addr = 16'($urandom);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cs3_n", 32'(cs3_n), 32'(e.cs3));
        chk("wait3_n", 32'(wait3_n), 32'(e.w3));
        chk("bank", 32'(bank3), 32'(e.bank));
        chk("cs4_n", 32'(cs4_n), 32'(e.cs4));
        chk("wait4_n", 32'(wait4_n), 32'd1);
`ifndef KONAMI_DECODE_WATCHDOG_EN
        chk("wd_rst_n", 32'({wd3_n, wd4_n}), 32'b11);
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] a;
    int cat;
    reset_n = 1'b0; vma = 1'b0; rw = 1'b1; addr = '0; dout = '0;
    #12;
    chk("reset_cs3", 32'(cs3_n), 32'b111);
    chk("reset_wait", 32'(wait3_n), 32'd1);
    chk("reset_bank", 32'(bank3), 32'd0);
    chk("reset_wd", 32'(wd3_n), 32'd1);
    @(negedge clk) reset_n = 1'b1;
    access(16'h0123, 1'b0, 8'h00, 2, 1, 16'h0123);
    access(16'h4010, 1'b0, 8'h00, 4, 1, 16'h0000);
    access(16'h5F85, 1'b1, 8'hF3, 2, 1, 16'h5F85);
    access(16'h5F85, 1'b0, 8'h00, 2, 1, 16'h5F85);
    access(16'h9000, 1'b0, 8'h00, 3, 2, 16'h4000);
    access(16'h0010, 1'b0, 8'h00, 2, 1, 16'h0010);
    access(16'h4000, 1'b0, 8'h00, 1, 2, 16'h4000);
    access(16'h4000, 1'b1, 8'h55, 2, 1, 16'h0000);
    access(16'h5F80, 1'b1, 8'h1F, 1, 1, 16'h5F80);
    @(negedge clk);
    addr = 16'h4000; rw = 1'b1; vma = 1'b1;
    @(posedge clk);
    #2;
    chk("wait_before_reset", 32'(wait3_n), 32'd0);
    chk("cs_before_reset", 32'(cs3_n), 32'b011);
    #1 reset_n = 1'b0;
    #1;
    chk("async_cs3", 32'(cs3_n), 32'b111);
    chk("async_wait", 32'(wait3_n), 32'd1);
    chk("async_bank", 32'(bank3), 32'd0);
    chk("async_cs4", 32'(cs4_n), 32'b1111);
    vma = 1'b0; mbank = '0;
    @(negedge clk) reset_n = 1'b1;
    for (int n = 0; n < 300; n++) begin
      cat = $urandom_range(0, 4);
      a = cat == 0 ? 16'($urandom_range(0, 16'h1FFF)) :
          cat == 1 ? 16'($urandom_range(16'h4000, 16'h7FFF)) :
          cat == 2 ? 16'($urandom_range(16'h5F80, 16'h5F8F)) :
          cat == 3 ? 16'($urandom_range(16'h8000, 16'hFFFF)) : 16'($urandom);
      access(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 5), $urandom_range(1, 2), 16'($urandom));
    end
`ifdef KONAMI_DECODE_WATCHDOG_EN
    reset_n = 1'b0; mbank = '0;
    @(negedge clk) reset_n = 1'b1;
    wd_lows = 0;
    repeat (99) @(negedge clk);
    chk("wd_early", 32'(wd_lows), 32'd0);
    repeat (60) @(negedge clk);
    chk("wd_pulse_len", 32'(wd_lows), 32'd16);
    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    wd_lows = 0;
    repeat (6) access(16'h0000, 1'b1, 8'h00, 1, 49, 16'h0000);
    chk("wd_kicked", 32'(wd_lows), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
